mem_responder: RTL and testbench

//  Memory-side responder for the multicycle core's MAR/MDR bus. Accepts one read or write

---
 rtl/mem_responder_pkg.sv | 14 +
 rtl/mem_responder_mem_array.sv | 47 ++++
 rtl/mem_responder.sv | 126 ++++++++++++
 tb/tb_mem_responder.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder memory-side responder.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    MEMR_IDLE,
    MEMR_WAIT,
    MEMR_RESP
  } mem_resp_state_t;

  localparam int unsigned MEM_WMASK_W = 4;
  // Wide enough for LATENCY up to 15.
  localparam int unsigned MEM_CNT_W   = 4;

endpackage

// File: rtl/mem_responder_mem_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// The read register only loads on re_i, so it holds the word until the response.
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   we_i,
  input  logic                   re_i,
  input  logic [IDX_W-1:0]       idx_i,
  input  logic [DATA_W-1:0]      wdata_i,
  input  logic [MEM_WMASK_W-1:0] wmask_i,
  output logic [DATA_W-1:0]      rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;
  logic              in_range;

  // Guards non-power-of-two depths; constant true otherwise.
  assign in_range = 32'(idx_i) < DEPTH;

  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = in_range ? mem_q[idx_i] : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    rdata_q <= rdata_d;
    if (we_i && in_range) begin
      for (int b = 0; b < MEM_WMASK_W; b++) begin
        if (wmask_i[b]) begin
          mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder for the MAR/MDR bus: accept, wait LATENCY, pulse rsp_valid.
// Optional feature macro: MEM_RESP_ERR_CHECK_EN (misaligned / out-of-range fault reporting).
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  input  logic                   req_we,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  input  logic [MEM_WMASK_W-1:0] req_wmask,
  output logic                   req_ready,
  output logic                   rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err
);

  localparam int unsigned          IdxW    = $clog2(DEPTH);
  localparam logic [MEM_CNT_W-1:0] CntInit = MEM_CNT_W'(LATENCY - 1);

  mem_resp_state_t       state_d, state_q;
  logic [MEM_CNT_W-1:0]  cnt_d, cnt_q;
  logic                  we_d, we_q;
  logic                  err_d, err_q;

  logic [IdxW-1:0]       word_idx;
  logic                  req_err;
  logic                  accept;
  logic                  ram_we;
  logic                  ram_re;
  logic [DATA_W-1:0]     ram_rdata;

  assign word_idx = req_addr[2 +: IdxW];

`ifdef MEM_RESP_ERR_CHECK_EN
  logic misaligned;
  logic out_of_range;

  assign misaligned   = req_addr[1:0] != 2'b00;
  // Catches both index >= DEPTH and nonzero bits above the index field.
  assign out_of_range = (req_addr >> 2) >= ADDR_W'(DEPTH);
  assign req_err      = misaligned || out_of_range;
`else
  logic unused_addr;

  assign unused_addr = ^req_addr;
  assign req_err     = 1'b0;
`endif

  assign accept = req_valid && (state_q == MEMR_IDLE);
  assign ram_we = accept && req_we && !req_err;
  assign ram_re = accept && !req_we && !req_err;

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IdxW)
  ) u_mem_array (
    .clk_i   (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .idx_i   (word_idx),
    .wdata_i (req_wdata),
    .wmask_i (req_wmask),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    err_d     = err_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;

    unique case (state_q)
      MEMR_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          err_d   = req_err;
          cnt_d   = CntInit;
          state_d = (LATENCY == 1) ? MEMR_RESP : MEMR_WAIT;
        end
      end
      MEMR_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = MEMR_RESP;
        end
      end
      MEMR_RESP: begin
        rsp_valid = 1'b1;
        state_d   = MEMR_IDLE;
      end
      default: begin
        state_d = MEMR_IDLE;
      end
    endcase
  end

  // Writes and faulting accesses return zero data; the pulse is then just an ack.
  assign rsp_rdata = (rsp_valid && !we_q && !err_q) ? ram_rdata : '0;
  assign rsp_err   = rsp_valid && err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MEMR_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: cycle-level reference model plus directed checks.
module tb_mem_responder;

  localparam int unsigned LAT    = 2;
  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned NWORDS = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wmask = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        xv [2];
  logic        xr [2];
  logic        xrv [2];
  logic        xerr [2];
  logic [31:0] xrd [2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .DEPTH   (DEPTH),
    .LATENCY (LAT)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wmask (req_wmask),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  mem_responder #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .DEPTH   (DEPTH),
    .LATENCY (1)
  ) u_dut_l1 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (xv[0]),
    .req_we    (1'b0),
    .req_addr  (32'h10),
    .req_wdata (32'h0),
    .req_wmask (4'h0),
    .req_ready (xr[0]),
    .rsp_valid (xrv[0]),
    .rsp_rdata (xrd[0]),
    .rsp_err   (xerr[0])
  );

  mem_responder #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .DEPTH   (DEPTH),
    .LATENCY (15)
  ) u_dut_l15 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (xv[1]),
    .req_we    (1'b0),
    .req_addr  (32'h10),
    .req_wdata (32'h0),
    .req_wmask (4'h0),
    .req_ready (xr[1]),
    .rsp_valid (xrv[1]),
    .rsp_rdata (xrd[1]),
    .rsp_err   (xerr[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE0000 ^ (32'(i) * 32'h01010101);
  endfunction

  function automatic bit addr_err(input logic [31:0] a);
`ifdef MEM_RESP_ERR_CHECK_EN
    return (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
`else
    return (a === 32'hx);
`endif
  endfunction

  // Reference model: a response is owed exactly LAT cycles after each accepted request,
  // and the responder is busy until that response has been delivered.
  logic [31:0] mmem [DEPTH];
  bit          started = 1'b0;
  int          busy_until = 0;
  int          rsp_at = -1;
  logic [31:0] exp_rd = '0;
  bit          exp_err = 1'b0;

  always @(negedge clk) begin
    bit m_ready;
    bit m_rv;
    bit e;
    int w;
    if (!started) begin
      if (rst) begin
        started    = 1'b1;
        busy_until = cyc;
        rsp_at     = -1;
      end
    end else begin
      m_ready = cyc > busy_until;
      m_rv    = cyc == rsp_at;
      check("req_ready", req_ready, m_ready);
      check("rsp_valid", rsp_valid, m_rv);
      check("rsp_rdata", rsp_rdata, m_rv ? exp_rd : 32'h0);
      check("rsp_err", rsp_err, m_rv && exp_err);
      if (rst) begin
        busy_until = cyc;
        rsp_at     = -1;
      end else if (m_ready && req_valid) begin
        w          = int'((req_addr >> 2) % DEPTH);
        e          = addr_err(req_addr);
        busy_until = cyc + LAT;
        rsp_at     = cyc + LAT;
        exp_err    = e;
        exp_rd     = (req_we || e) ? 32'h0 : mmem[w];
        if (req_we && !e) begin
          for (int b = 0; b < 4; b++) begin
            if (req_wmask[b]) mmem[w][8*b +: 8] = req_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) sync();
  endtask

  // Called just after a rising edge; leaves req_valid high so requests can run back-to-back.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] mask, output int acc);
    int n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = mask;
    acc       = -1;
    while (acc < 0) begin
      @(negedge clk);
      if (req_ready) begin
        acc = cyc;
      end else if (++n > 40) begin
        n_tests++;
        n_fail++;
        $display("FAIL accept_timeout: got no accept expected one within 40 cycles");
        break;
      end
    end
    sync();
  endtask

  task automatic wait_rsp(output logic [31:0] rd, output logic er, output int at);
    int n = 0;
    at = -1;
    rd = '0;
    er = 1'b0;
    while (at < 0) begin
      @(negedge clk);
      if (rsp_valid) begin
        at = cyc;
        rd = rsp_rdata;
        er = rsp_err;
      end else if (++n > 40) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_timeout: got no rsp_valid expected one within 40 cycles");
        break;
      end
    end
    sync();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected one before time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          t;
    int          ta;
    int          a0;
    int          a1;
    int          a2;
    logic [31:0] a;
    int          sel;
    xv[0] = 1'b0;
    xv[1] = 1'b0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", req_ready, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_rdata", rsp_rdata, 0);
    check("reset_rsp_err", rsp_err, 0);
    sync();

    for (int i = 0; i < int'(NWORDS); i++) do_req(1'b1, 32'(i * 4), init_word(i), 4'hF, t);
    idle(LAT + 2);

    // Basic read latency and busy window
    do_req(1'b0, 32'h10, 32'h0, 4'h0, t);
    idle(0);
    @(negedge clk);
    check("t1_busy", req_ready, 0);
    wait_rsp(rd, er, ta);
    check("t1_latency", 32'(ta - t), LAT);
    check("t1_rdata", rd, init_word(4));
    @(negedge clk);
    check("t1_pulse_end", rsp_valid, 0);
    check("t1_ready_back", req_ready, 1);
    sync();

    // Masked byte merge
    do_req(1'b1, 32'h20, 32'hDEADBEEF, 4'b1111, t);
    idle(0);
    wait_rsp(rd, er, ta);
    check("t2_wr_ack_rdata", rd, 0);
    do_req(1'b1, 32'h20, 32'h000000AA, 4'b0001, t);
    idle(0);
    wait_rsp(rd, er, ta);
    do_req(1'b0, 32'h20, 32'h0, 4'h0, t);
    idle(0);
    wait_rsp(rd, er, ta);
    check("t2_rdata", rd, 32'hDEADBEAA);
    check("t2_err", er, 0);

    // Zero-mask write changes nothing but is acknowledged
    do_req(1'b1, 32'h20, 32'h11223344, 4'b0000, t);
    idle(0);
    wait_rsp(rd, er, ta);
    check("t2_zero_mask_ack", 32'(ta - t), LAT);
    do_req(1'b0, 32'h20, 32'h0, 4'h0, t);
    idle(0);
    wait_rsp(rd, er, ta);
    check("t2_zero_mask_rdata", rd, 32'hDEADBEAA);

    // Back-to-back reads with req_valid held
    do_req(1'b0, 32'h0, 32'h0, 4'h0, a0);
    do_req(1'b0, 32'h4, 32'h0, 4'h0, a1);
    do_req(1'b0, 32'h8, 32'h0, 4'h0, a2);
    idle(0);
    check("t3_spacing_1", 32'(a1 - a0), LAT + 1);
    check("t3_spacing_2", 32'(a2 - a1), LAT + 1);
    idle(LAT + 2);

    // Reset one cycle after accept drops the transaction
    do_req(1'b0, 32'h4, 32'h0, 4'h0, t);
    idle(0);
    rst = 1'b1;
    sync();
    rst = 1'b0;
    @(negedge clk);
    check("t4_ready", req_ready, 1);
    check("t4_no_rsp", rsp_valid, 0);
    for (int i = 0; i < int'(LAT) + 2; i++) begin
      @(negedge clk);
      check("t4_no_rsp_later", rsp_valid, 0);
    end
    sync();

`ifdef MEM_RESP_ERR_CHECK_EN
    do_req(1'b0, 32'h22, 32'h0, 4'h0, t);
    idle(0);
    wait_rsp(rd, er, ta);
    check("t5_misaligned_err", er, 1);
    check("t5_misaligned_rdata", rd, 0);
    do_req(1'b1, 32'h1000, 32'h12345678, 4'hF, t);
    idle(0);
    wait_rsp(rd, er, ta);
    check("t5_oor_write_err", er, 1);
    do_req(1'b0, 32'h0, 32'h0, 4'h0, t);
    idle(0);
    wait_rsp(rd, er, ta);
    check("t5_word0_unchanged", rd, init_word(0));
    check("t5_word0_err", er, 0);
`else
    do_req(1'b0, 32'h1000, 32'h0, 4'h0, t);
    idle(0);
    wait_rsp(rd, er, ta);
    check("t5_wrap_err", er, 0);
    check("t5_wrap_rdata", rd, init_word(0));
`endif

    // Randomised traffic with occasional resets
    for (int k = 0; k < 300; k++) begin
      a   = 32'($urandom_range(0, NWORDS - 1) * 4);
      sel = int'($urandom_range(0, 9));
      if (sel == 0) a[1:0] = 2'($urandom_range(1, 3));
      else if (sel == 1) a = a | 32'h1000;
      do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), t);
      if ($urandom_range(0, 25) == 0) begin
        idle(int'($urandom_range(0, 2)));
        rst = 1'b1;
        sync();
        rst = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        idle(int'($urandom_range(0, 4)));
      end
    end
    idle(LAT + 3);

    // Latency extremes on the side instances
    for (int k = 0; k < 2; k++) begin
      int exp_lat;
      int n;
      exp_lat = (k == 0) ? 1 : 15;
      xv[k] = 1'b1;
      @(negedge clk);
      check("t6_ready", xr[k], 1);
      t = cyc;
      sync();
      xv[k] = 1'b0;
      ta = -1;
      n  = 0;
      while (ta < 0 && n < 40) begin
        @(negedge clk);
        if (xrv[k]) ta = cyc;
        n++;
      end
      check("t6_latency", 32'(ta - t), 32'(exp_lat));
      check("t6_err", xerr[k], 0);
      @(negedge clk);
      check("t6_pulse_end", xrv[k], 0);
      sync();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
